dac_sample_scheduler: RTL and testbench
=======================================

Name: dac_sample_scheduler

Overview:
Sequencing front-end for the FIR -> sigma-delta DAC chain. It assembles 16-bit signed samples from an 8-bit byte stream and buffers them in a small FIFO. Samples are released to the filter input at a programmable sample rate. A start/prime/run state machine and underrun policy keep the DAC fed with defined data.

Parameters:
BW, 16, sample width; must equal 2*8 (two bytes per sample)
DEPTH, 4, FIFO depth in samples; power of two, >= 2
DIV_W, 12, width of the sample-period divider

Ports:
clk  in  1  system clock
rst_i  in  1  synchronous reset, active-high
byte_i  in  8  input byte, low byte first then high byte
byte_valid_i  in  1  byte_i valid
byte_ready_o  out  1  byte accepted when valid && ready
enable_i  in  1  playback enable
cfg_div_i  in  DIV_W  sample period minus 1, in clk cycles
cfg_mute_i  in  1  underrun policy: 0 = hold last sample, 1 = output zero
sample_o  out  BW  signed sample to filter_FIR input
sample_stb_o  out  1  one-cycle pulse when sample_o is updated
underrun_o  out  1  sticky underrun flag
fifo_level_o  out  $clog2(DEPTH)+1  FIFO occupancy
run_o  out  1  high in RUN state

Behaviour:
- All state updates on the rising clk edge. rst_i is synchronous and active-high, applied on the rising edge of clk.
- Reset values:
  - sample_o=0, sample_stb_o=0, underrun_o=0, run_o=0
  - FIFO empty, fifo_level_o=0
  - assembler in LOW, FSM in IDLE, divider counter=0
- Byte assembler (2 states):
  - LOW: byte accepted -> store as low byte, go to HIGH.
  - HIGH: byte accepted -> push {byte_i, low} into FIFO, go to LOW.
  - byte_ready_o = 1 in LOW. In HIGH, byte_ready_o = !full, using the registered full flag. A pop in the same cycle does not open a slot.
  - The assembler runs independently of enable_i.
- FIFO:
  - Synchronous, DEPTH entries.
  - Push and pop in the same cycle: level unchanged, order preserved.
  - Pointers wrap modulo DEPTH.
  - fifo_level_o reflects the count after the edge.
- Controller FSM:
  - IDLE: divider held at 0, run_o=0. enable_i=1 -> PRIME.
  - PRIME: clears underrun_o on entry cycle. When level >= DEPTH/2, go to RUN and load the divider with cfg_div_i.
  - RUN: divider counts down. Tick when counter==0; on tick, reload from cfg_div_i as sampled on that cycle. The first tick occurs cfg_div_i+1 cycles after entering RUN; cfg_div_i=0 ticks every cycle.
  - enable_i=0 in any state -> IDLE next cycle. sample_o <= 0 with no strobe, and FIFO contents and assembler state are retained.
- Tick action (RUN only), with registered outputs visible the cycle after the tick:
  - FIFO non-empty: pop the head, sample_o <= head, sample_stb_o=1.
  - FIFO empty: underrun_o <= 1. sample_o keeps its value (cfg_mute_i=0) or becomes 0 (cfg_mute_i=1). sample_stb_o=1 regardless.
  - FSM stays in RUN after an underrun and does not return to PRIME.
- sample_stb_o is exactly one cycle wide, and at most one per tick.
- rst_i mid-operation discards the FIFO and any half-assembled byte pair. All outputs return to their reset values on the next edge.
- Sign handling: samples are two's complement, passed through unmodified. Example: 0x8000 = most negative.

Test Plan:
- Reset: assert rst_i 2 cycles mid-stream with FIFO level 3 -> level=0, sample_o=0, run_o=0, byte_ready_o=1, assembler back to LOW.
- Assembly/order: send bytes 34,12,CD,AB with cfg_div_i=3, DEPTH=4, enable=1:
  - run_o rises once level=2;
  - strobes every 4 cycles;
  - sample_o = 0x1234 then 0xABCD.
- Backpressure: hold enable_i=0 and stream 10 bytes -> after 8 bytes level=4, byte_ready_o=0 in HIGH with byte 9 pending as low byte, no byte lost.
- Underrun hold/mute: play 0x7FFF then starve, cfg_mute_i=0:
  - next tick strobes with sample_o=0x7FFF and underrun_o=1;
  - repeat with cfg_mute_i=1 -> sample_o=0x0000.
  - Re-enable -> underrun_o cleared in PRIME.
- Max rate plus simultaneous push/pop: cfg_div_i=0, continuous byte feed -> one strobe per cycle while data lasts, level never exceeds 4, output sequence equals input sequence.
- Disable mid-run: deassert enable_i with level=2 -> next cycle run_o=0 and sample_o=0 with no strobe. Level stays 2, and the remaining samples play first after re-enable.

Source files
------------

// File: rtl/dac_sample_scheduler.sv
// Byte-to-sample assembler, sample FIFO and rate-controlled release FSM
// feeding the FIR -> sigma-delta DAC chain.
module dac_sample_scheduler #(
  parameter int BW    = 16,
  parameter int DEPTH = 4,
  parameter int DIV_W = 12
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic [7:0]                 byte_i,
  input  logic                       byte_valid_i,
  output logic                       byte_ready_o,
  input  logic                       enable_i,
  input  logic [DIV_W-1:0]           cfg_div_i,
  input  logic                       cfg_mute_i,
  output logic signed [BW-1:0]       sample_o,
  output logic                       sample_stb_o,
  output logic                       underrun_o,
  output logic [$clog2(DEPTH):0]     fifo_level_o,
  output logic                       run_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

  state_t                     state_q, state_d;
  logic                       asm_hi_q, asm_hi_d;
  logic [7:0]                 low_q, low_d;
  logic [DEPTH-1:0][BW-1:0]   mem_q, mem_d;
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]              level_q, level_d;
  logic [DIV_W-1:0]           cnt_q, cnt_d;
  logic [BW-1:0]              sample_q, sample_d;
  logic                       stb_q, stb_d;
  logic                       underrun_q, underrun_d;

  logic full, empty, accept, push, pop;

  always_comb begin
    asm_hi_d   = asm_hi_q;
    low_d      = low_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    sample_d   = sample_q;
    stb_d      = 1'b0;
    underrun_d = underrun_q;
    push       = 1'b0;
    pop        = 1'b0;

    full         = (level_q == LW'(DEPTH));
    empty        = (level_q == '0);
    // Ready only looks at registered state, so a pop this cycle cannot free a slot.
    byte_ready_o = !asm_hi_q || !full;
    accept       = byte_valid_i && byte_ready_o;

    if (accept) begin
      if (!asm_hi_q) begin
        low_d    = byte_i;
        asm_hi_d = 1'b1;
      end else begin
        push     = 1'b1;
        asm_hi_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        cnt_d    = '0;
        sample_d = '0;
        if (enable_i) state_d = S_PRIME;
      end
      S_PRIME: begin
        underrun_d = 1'b0;
        if (!enable_i) begin
          state_d  = S_IDLE;
          sample_d = '0;
        end else if (level_q >= LW'(DEPTH / 2)) begin
          state_d = S_RUN;
          cnt_d   = cfg_div_i;
        end
      end
      S_RUN: begin
        if (!enable_i) begin
          state_d  = S_IDLE;
          sample_d = '0;
          cnt_d    = '0;
        end else if (cnt_q == '0) begin
          cnt_d = cfg_div_i;
          stb_d = 1'b1;
          if (!empty) begin
            pop      = 1'b1;
            sample_d = mem_q[rd_ptr_q];
          end else begin
            underrun_d = 1'b1;
            if (cfg_mute_i) sample_d = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = {byte_i, low_q};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      asm_hi_q   <= 1'b0;
      low_q      <= '0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cnt_q      <= '0;
      sample_q   <= '0;
      stb_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      asm_hi_q   <= asm_hi_d;
      low_q      <= low_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      sample_q   <= sample_d;
      stb_q      <= stb_d;
      underrun_q <= underrun_d;
    end
  end

  assign sample_o     = sample_q;
  assign sample_stb_o = stb_q;
  assign underrun_o   = underrun_q;
  assign fifo_level_o = level_q;
  assign run_o        = (state_q == S_RUN);
endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler: reset, assembly order, backpressure,
// underrun policy, max-rate streaming and disable/re-enable.
module tb_dac_sample_scheduler;
  localparam int BW = 16, DEPTH = 4, DIV_W = 12;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [7:0]        byte_i = '0;
  logic              byte_valid_i = 1'b0;
  logic              byte_ready_o;
  logic              enable_i = 1'b0;
  logic [DIV_W-1:0]  cfg_div_i = '0;
  logic              cfg_mute_i = 1'b0;
  logic [BW-1:0]     sample_o;
  logic              sample_stb_o;
  logic              underrun_o;
  logic [2:0]        fifo_level_o;
  logic              run_o;

  int checks = 0;
  int errors = 0;

  logic [15:0] mr_vec [8];

  dac_sample_scheduler #(.BW(BW), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_i(rst_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o), .enable_i(enable_i), .cfg_div_i(cfg_div_i),
    .cfg_mute_i(cfg_mute_i), .sample_o(sample_o), .sample_stb_o(sample_stb_o),
    .underrun_o(underrun_o), .fifo_level_o(fifo_level_o), .run_o(run_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    byte_valid_i = 1'b0;
    enable_i     = 1'b0;
    rst_i        = 1'b1;
    step(); step();
    rst_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    bit   done;
    done = 0;
    byte_i = b;
    byte_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (!done) begin
        rdy = byte_ready_o;
        step();
        if (rdy) done = 1;
      end
    end
    byte_valid_i = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_byte timeout: byte %h never accepted", b);
    end
  endtask

  task automatic wait_stb(output bit got);
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (!got) begin
        step();
        if (sample_stb_o) got = 1;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; step(); step(); rst_i = 1'b0;
    checks++; if ({sample_o, sample_stb_o, underrun_o, run_o, fifo_level_o, byte_ready_o} !== {16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1}) begin
      errors++; $display("FAIL reset_initial: sample=%h stb=%b ur=%b run=%b lvl=%0d rdy=%b, want 0 0 0 0 0 1",
                         sample_o, sample_stb_o, underrun_o, run_o, fifo_level_o, byte_ready_o);
    end
    for (int i = 0; i < 7; i++) send_byte(8'h40 + 8'(i));
    checks++; if (fifo_level_o !== 3'd3) begin
      errors++; $display("FAIL reset_prefill_level: got %0d want 3", fifo_level_o);
    end
    byte_i = 8'h99; byte_valid_i = 1'b1;
    rst_i = 1'b1; step(); step(); rst_i = 1'b0; byte_valid_i = 1'b0;
    checks++; if ({fifo_level_o, sample_o, run_o, byte_ready_o} !== {3'd0, 16'h0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_midstream: lvl=%0d sample=%h run=%b rdy=%b, want 0 0000 0 1",
                         fifo_level_o, sample_o, run_o, byte_ready_o);
    end
    send_byte(8'h11);
    checks++; if (fifo_level_o !== 3'd0) begin
      errors++; $display("FAIL reset_asm_low: level after one byte got %0d want 0", fifo_level_o);
    end
    send_byte(8'h22);
    checks++; if (fifo_level_o !== 3'd1) begin
      errors++; $display("FAIL reset_asm_pair: level got %0d want 1", fifo_level_o);
    end
  endtask

  task automatic test_assembly();
    int          idx [3];
    logic [15:0] val [3];
    logic        ur  [3];
    int          n;
    do_reset();
    cfg_div_i = 12'd3; cfg_mute_i = 1'b0; enable_i = 1'b1;
    send_byte(8'h34); send_byte(8'h12);
    checks++; if ({fifo_level_o, run_o} !== {3'd1, 1'b0}) begin
      errors++; $display("FAIL asm_prime_wait: lvl=%0d run=%b want 1 0", fifo_level_o, run_o);
    end
    send_byte(8'hCD); send_byte(8'hAB);
    n = 0;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 1) begin
        checks++; if (run_o !== 1'b1) begin
          errors++; $display("FAIL asm_run_rise: run=%b want 1", run_o);
        end
      end
      if (sample_stb_o && n < 3) begin
        idx[n] = c; val[n] = sample_o; ur[n] = underrun_o; n++;
      end
    end
    checks++; if (n !== 3) begin
      errors++; $display("FAIL asm_strobe_count: got %0d want 3", n);
    end else begin
      checks++; if ({idx[0], idx[1], idx[2]} !== {32'd5, 32'd9, 32'd13}) begin
        errors++; $display("FAIL asm_strobe_timing: got %0d %0d %0d want 5 9 13", idx[0], idx[1], idx[2]);
      end
      checks++; if ({val[0], ur[0], val[1], ur[1]} !== {16'h1234, 1'b0, 16'hABCD, 1'b0}) begin
        errors++; $display("FAIL asm_order: got %h/%b %h/%b want 1234/0 abcd/0", val[0], ur[0], val[1], ur[1]);
      end
      checks++; if ({val[2], ur[2]} !== {16'hABCD, 1'b1}) begin
        errors++; $display("FAIL asm_underrun_hold: got %h/%b want abcd/1", val[2], ur[2]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_v [5];
    logic [15:0] got_v [5];
    int          n;
    bit          pending;
    logic        rdy;
    bit          stuck_ok;
    exp_v = '{16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09};
    do_reset();
    cfg_div_i = 12'd0; cfg_mute_i = 1'b0;
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    checks++; if ({fifo_level_o, byte_ready_o} !== {3'd4, 1'b1}) begin
      errors++; $display("FAIL bp_full: lvl=%0d rdy=%b want 4 1", fifo_level_o, byte_ready_o);
    end
    send_byte(8'h09);
    checks++; if ({fifo_level_o, byte_ready_o} !== {3'd4, 1'b0}) begin
      errors++; $display("FAIL bp_stall: lvl=%0d rdy=%b want 4 0", fifo_level_o, byte_ready_o);
    end
    byte_i = 8'h0A; byte_valid_i = 1'b1;
    stuck_ok = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (byte_ready_o !== 1'b0 || fifo_level_o !== 3'd4) stuck_ok = 0;
    end
    checks++; if (!stuck_ok) begin
      errors++; $display("FAIL bp_hold: ready/level moved while stalled, rdy=%b lvl=%0d want 0 4", byte_ready_o, fifo_level_o);
    end
    enable_i = 1'b1; pending = 1; n = 0;
    for (int c = 0; c < 40; c++) begin
      rdy = byte_ready_o;
      step();
      if (pending && rdy) begin pending = 0; byte_valid_i = 1'b0; end
      if (sample_stb_o && n < 5) begin got_v[n] = sample_o; n++; end
    end
    byte_valid_i = 1'b0;
    checks++; if (n !== 5) begin
      errors++; $display("FAIL bp_count: got %0d strobes want 5", n);
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++; if (got_v[k] !== exp_v[k]) begin
          errors++; $display("FAIL bp_order[%0d]: got %h want %h", k, got_v[k], exp_v[k]);
        end
      end
    end
  endtask

  task automatic test_underrun();
    bit got;
    do_reset();
    cfg_div_i = 12'd1; cfg_mute_i = 1'b0; enable_i = 1'b1;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hFF); send_byte(8'h7F);
    wait_stb(got);
    checks++; if ({got, sample_o, underrun_o} !== {1'b1, 16'h0001, 1'b0}) begin
      errors++; $display("FAIL ur_first: got=%b sample=%h ur=%b want 1 0001 0", got, sample_o, underrun_o);
    end
    wait_stb(got);
    checks++; if ({got, sample_o, underrun_o} !== {1'b1, 16'h7FFF, 1'b0}) begin
      errors++; $display("FAIL ur_second: got=%b sample=%h ur=%b want 1 7fff 0", got, sample_o, underrun_o);
    end
    wait_stb(got);
    checks++; if ({got, sample_o, underrun_o, run_o} !== {1'b1, 16'h7FFF, 1'b1, 1'b1}) begin
      errors++; $display("FAIL ur_hold: got=%b sample=%h ur=%b run=%b want 1 7fff 1 1", got, sample_o, underrun_o, run_o);
    end
    cfg_mute_i = 1'b1;
    wait_stb(got);
    checks++; if ({got, sample_o, underrun_o} !== {1'b1, 16'h0000, 1'b1}) begin
      errors++; $display("FAIL ur_mute: got=%b sample=%h ur=%b want 1 0000 1", got, sample_o, underrun_o);
    end
    enable_i = 1'b0; step();
    checks++; if ({run_o, underrun_o} !== {1'b0, 1'b1}) begin
      errors++; $display("FAIL ur_sticky_idle: run=%b ur=%b want 0 1", run_o, underrun_o);
    end
    enable_i = 1'b1; step(); step();
    checks++; if ({run_o, underrun_o} !== {1'b0, 1'b0}) begin
      errors++; $display("FAIL ur_clear_prime: run=%b ur=%b want 0 0", run_o, underrun_o);
    end
  endtask

  task automatic test_max_rate();
    logic [15:0] got_v [8];
    int n, missing, maxlvl;
    logic run_prev;
    do_reset();
    cfg_div_i = 12'd0; cfg_mute_i = 1'b1; enable_i = 1'b1;
    n = 0; missing = 0; maxlvl = 0; run_prev = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send_byte(mr_vec[i][7:0]);
          send_byte(mr_vec[i][15:8]);
        end
      end
      begin
        for (int c = 0; c < 60; c++) begin
          step();
          if (int'(fifo_level_o) > maxlvl) maxlvl = int'(fifo_level_o);
          if (run_prev && !sample_stb_o) missing++;
          run_prev = run_o;
          if (sample_stb_o && sample_o != 16'h0 && n < 8) begin got_v[n] = sample_o; n++; end
        end
      end
    join
    checks++; if (maxlvl > 4) begin
      errors++; $display("FAIL mr_level: max level %0d want <= 4", maxlvl);
    end
    checks++; if (missing !== 0) begin
      errors++; $display("FAIL mr_rate: %0d RUN cycles without strobe want 0", missing);
    end
    checks++; if (n !== 8) begin
      errors++; $display("FAIL mr_count: got %0d samples want 8", n);
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++; if (got_v[k] !== mr_vec[k]) begin
          errors++; $display("FAIL mr_order[%0d]: got %h want %h", k, got_v[k], mr_vec[k]);
        end
      end
    end
  endtask

  task automatic test_disable();
    bit got;
    int stbs;
    do_reset();
    cfg_div_i = 12'd3; cfg_mute_i = 1'b0;
    send_byte(8'h11); send_byte(8'h11); send_byte(8'h22); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h33); send_byte(8'h44); send_byte(8'h44);
    enable_i = 1'b1;
    wait_stb(got);
    wait_stb(got);
    checks++; if ({got, sample_o, fifo_level_o} !== {1'b1, 16'h2222, 3'd2}) begin
      errors++; $display("FAIL dis_pre: got=%b sample=%h lvl=%0d want 1 2222 2", got, sample_o, fifo_level_o);
    end
    enable_i = 1'b0; step();
    checks++; if ({run_o, sample_o, sample_stb_o, fifo_level_o} !== {1'b0, 16'h0, 1'b0, 3'd2}) begin
      errors++; $display("FAIL dis_off: run=%b sample=%h stb=%b lvl=%0d want 0 0000 0 2",
                         run_o, sample_o, sample_stb_o, fifo_level_o);
    end
    stbs = 0;
    for (int i = 0; i < 3; i++) begin step(); if (sample_stb_o) stbs++; end
    checks++; if (stbs !== 0 || fifo_level_o !== 3'd2) begin
      errors++; $display("FAIL dis_idle: strobes=%0d lvl=%0d want 0 2", stbs, fifo_level_o);
    end
    enable_i = 1'b1;
    wait_stb(got);
    checks++; if ({got, sample_o} !== {1'b1, 16'h3333}) begin
      errors++; $display("FAIL dis_resume0: got=%b sample=%h want 1 3333", got, sample_o);
    end
    wait_stb(got);
    checks++; if ({got, sample_o} !== {1'b1, 16'h4444}) begin
      errors++; $display("FAIL dis_resume1: got=%b sample=%h want 1 4444", got, sample_o);
    end
  endtask

  initial begin
    mr_vec = '{16'h8000, 16'h0001, 16'hFFFF, 16'h1234, 16'h55AA, 16'h7FFF, 16'h0F0F, 16'hC3C3};
    test_reset();
    test_assembly();
    test_backpressure();
    test_underrun();
    test_max_rate();
    test_disable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
